// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and flag packing for the sequential ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_CAT = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int FLG_Z  = 0;
   localparam int FLG_C  = 1;
   localparam int FLG_V  = 2;
   localparam int FLG_DZ = 3;

   function automatic logic [3:0] pack_flags(input logic dz, input logic v,
                                             input logic c, input logic z);
      logic [3:0] f;
      f         = '0;
      f[FLG_DZ] = dz;
      f[FLG_V]  = v;
      f[FLG_C]  = c;
      f[FLG_Z]  = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// W-step iterative unit: shift-add multiplier or restoring divider on a shared
// {hi, lo} register pair; done_o marks the final step, res_o is that step's value.
module alu_iter_unit #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic           div_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic           done_o,
   output logic [2*W-1:0] res_o
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  b_q;
   logic          div_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    sum;
   logic [W:0]    shl;
   logic [W:0]    dif;

   // mul: hi accumulates partial sums, lo shifts out multiplier bits and in product bits
   // div: {hi, lo} shifts left, hi is the partial remainder, lo collects quotient bits
   assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign shl = {hi_q, lo_q[W-1]};
   assign dif = shl - {1'b0, b_q};

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (cnt_q != '0) begin
         if (div_q) begin
            hi_d = dif[W] ? shl[W-1:0] : dif[W-1:0];
            lo_d = {lo_q[W-2:0], ~dif[W]};
         end else begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
         end
      end
   end

   assign done_o = (cnt_q == CW'(1));
   assign res_o  = {hi_d, lo_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (start_i) begin
         hi_q  <= '0;
         lo_q  <= a_i;
         b_q   <= b_i;
         div_q <= div_i;
         cnt_q <= CW'(W);
      end else if (cnt_q != '0) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked W-bit ALU with registered 2W-bit result and {DZ,V,C,Z} flags.
//   state  | meaning
//   S_IDLE | in_ready high, waiting for an operation
//   S_BUSY | iterative MUL/DIV in progress
//   S_DONE | result/flags valid, held until out_ready
module seq_alu
   import alu_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] result,
   output logic [3:0]     flags
);

   state_e         state_q, state_d;
   logic [2*W-1:0] result_q, result_d;
   logic [3:0]     flags_q, flags_d;
   op_e            op_c;
   logic           iter_op;
   logic           start;
   logic           it_done;
   logic [2*W-1:0] it_res;
   logic [W:0]     add_w;
   logic [W:0]     sub_w;
   logic [2*W-1:0] sc_res;
   logic           sc_c, sc_v, sc_dz;

   assign op_c    = op_e'(op);
   assign iter_op = (op_c == OP_MUL) || ((op_c == OP_DIV) && (b != '0));
   assign start   = in_valid && (state_q == S_IDLE) && iter_op;

   alu_iter_unit #(.W(W)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .div_i   (op_c == OP_DIV),
      .a_i     (a),
      .b_i     (b),
      .done_o  (it_done),
      .res_o   (it_res)
   );

   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};

   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_dz  = 1'b0;
      case (op_c)
         OP_ADD: begin
            sc_res = {{W{1'b0}}, add_w[W-1:0]};
            sc_c   = add_w[W];
            sc_v   = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
         end
         OP_SUB: begin
            sc_res = {{W{1'b0}}, sub_w[W-1:0]};
            sc_c   = sub_w[W];
            sc_v   = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
         end
         // only reaches the result register when b is zero
         OP_DIV: begin
            sc_res = {a, {W{1'b1}}};
            sc_dz  = 1'b1;
         end
         OP_AND:  sc_res = {{W{1'b0}}, a & b};
         OP_OR:   sc_res = {{W{1'b0}}, a | b};
         OP_XOR:  sc_res = {{W{1'b0}}, a ^ b};
         OP_CAT:  sc_res = {b, a};
         default: sc_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (iter_op) begin
                  state_d = S_BUSY;
               end else begin
                  result_d = sc_res;
                  flags_d  = pack_flags(sc_dz, sc_v, sc_c, sc_res == '0);
                  state_d  = S_DONE;
               end
            end
         end
         S_BUSY: begin
            if (it_done) begin
               result_d = it_res;
               flags_d  = pack_flags(1'b0, 1'b0, 1'b0, it_res == '0);
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with an arithmetic reference model checked every cycle.
module tb_seq_alu;

   localparam int W = 4;
   localparam int M = 1 << W;
   localparam int H = 1 << (W - 1);

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [2:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic [3:0]     flags;

   int n_tests = 0;
   int n_fail  = 0;

   seq_alu #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // returns {DZ,V,C,Z, result}
   function automatic logic [2*W+3:0] ref_op(input int o, input int x, input int y);
      int r, sx, sy, s;
      logic c, v, dz;
      logic [31:0] rv;
      c = 0; v = 0; dz = 0; r = 0;
      sx = (x >= H) ? x - M : x;
      sy = (y >= H) ? y - M : y;
      case (o)
         0: begin
            r = (x + y) % M; c = (x + y) >= M;
            s = sx + sy; v = (s >= H) || (s < -H);
         end
         1: begin
            r = (x - y + M) % M; c = x < y;
            s = sx - sy; v = (s >= H) || (s < -H);
         end
         2: r = x * y;
         3: begin
            if (y == 0) begin r = x * M + (M - 1); dz = 1; end
            else r = (x % y) * M + (x / y);
         end
         4: r = x & y;
         5: r = x | y;
         6: r = x ^ y;
         default: r = y * M + x;
      endcase
      rv = r;
      return {dz, v, c, (r == 0), rv[2*W-1:0]};
   endfunction

   function automatic bit is_iter(input int o, input int y);
      return (o == 2) || (o == 3 && y != 0);
   endfunction

   // reference model of the handshake: what the outputs must be after each edge
   logic           m_idle  = 1'b1;
   logic           m_valid = 1'b0;
   int             m_wait  = 0;
   logic [2*W-1:0] m_res   = '0;
   logic [3:0]     m_flg   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle  <= 1'b1;
         m_valid <= 1'b0;
         m_wait  <= 0;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
         end
      end else if (m_wait > 0) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_valid <= 1'b1;
      end else if (m_idle && in_valid) begin
         {m_flg, m_res} <= ref_op(op, a, b);
         m_idle <= 1'b0;
         if (is_iter(op, b)) m_wait <= W;
         else m_valid <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_result", result, 0);
         chk("rst_flags", flags, 0);
      end else begin
         chk("cyc_in_ready", in_ready, m_idle);
         chk("cyc_out_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("cyc_result", result, m_res);
            chk("cyc_flags", flags, m_flg);
         end
      end
   end

   // called #1 after a rising edge; returns the same way
   task automatic run_op(input int op_v, input int a_v, input int b_v,
                         input logic [7:0] exp_res, input logic [3:0] exp_flg,
                         input int exp_lat);
      logic [2*W+3:0] pin;
      int n;
      pin = ref_op(op_v, a_v, b_v);
      chk("model_res", pin[2*W-1:0], exp_res);
      chk("model_flg", pin[2*W+3:2*W], exp_flg);
      chk("accept_ready", in_ready, 1);
      in_valid = 1'b1; op = 3'(op_v); a = W'(a_v); b = W'(b_v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, exp_lat);
      chk("dut_res", result, exp_res);
      chk("dut_flg", flags, exp_flg);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", out_valid, 0);
      chk("release_ready", in_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", out_valid, 0);
      chk("init_result", result, 0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", in_ready, 1);
      @(posedge clk); #1;

      // op, a, b, result, {DZ,V,C,Z}, edges after accept
      run_op(0,  9, 8, 8'h01, 4'b0110, 0);
      run_op(1,  3, 5, 8'h0E, 4'b0010, 0);
      run_op(1,  5, 5, 8'h00, 4'b0001, 0);
      run_op(2, 15, 15, 8'hE1, 4'b0000, W);
      run_op(3, 13, 4, 8'h13, 4'b0000, W);
      run_op(3,  9, 0, 8'h9F, 4'b1000, 0);
      run_op(0,  7, 1, 8'h08, 4'b0100, 0);
      run_op(1,  8, 1, 8'h07, 4'b0100, 0);
      run_op(4, 12, 10, 8'h08, 4'b0000, 0);
      run_op(5,  0, 0, 8'h00, 4'b0001, 0);
      run_op(6, 15, 5, 8'h0A, 4'b0000, 0);
      run_op(3, 15, 1, 8'h0F, 4'b0000, W);
      run_op(3,  2, 3, 8'h20, 4'b0000, W);
      run_op(2,  0, 5, 8'h00, 4'b0001, W);
      run_op(3,  0, 0, 8'h0F, 4'b1000, 0);
      run_op(7,  3, 12, 8'hC3, 4'b0000, 0);

      // backpressure with input churn while DONE
      in_valid = 1'b1; op = 3'd7; a = 4'hA; b = 4'h5;
      @(posedge clk); #1;
      chk("bp_first_valid", out_valid, 1);
      chk("bp_first_res", result, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid; op = 3'(i); a = W'(i + 1); b = W'(i + 7);
         @(posedge clk); #1;
         chk("bp_hold_res", result, 8'h5A);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_ready", in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_rel_valid", out_valid, 0);
      chk("bp_rel_ready", in_ready, 1);

      // reset two cycles into a MUL
      in_valid = 1'b1; op = 3'd2; a = 4'd7; b = 4'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("mid_busy_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_result", result, 0);
      chk("abort_flags", flags, 0);
      @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk("abort_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("abort_idle_valid", out_valid, 0);
      run_op(2, 7, 6, 8'h2A, 4'b0000, W);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
